pfe_req_sched: RTL and testbench

PFE_REQ_SCHED -- requirements
Module: pfe_req_sched

---
 rtl/pfe_req_sched.sv | 151 +++++++++++++++
 tb/tb_pfe_req_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pfe_req_sched.sv
// Prefetch request scheduler: expands one prefetch op (base, stride, count) into
// line requests spread over two dcache ports, one new request per cycle at most.
module pfe_req_sched #(
    parameter int ADDR_W = 50,
    parameter int CNT_W  = 4,
    parameter int STR_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_valid,
    output logic                    op_retry,
    input  logic [ADDR_W-1:0]       op_addr,
    input  logic signed [STR_W-1:0] op_stride,
    input  logic [CNT_W-1:0]        op_count,
    output logic                    req0_valid,
    input  logic                    req0_retry,
    output logic [ADDR_W-1:0]       req0_addr,
    output logic                    req1_valid,
    input  logic                    req1_retry,
    output logic [ADDR_W-1:0]       req1_addr,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             issued_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
    logic signed [STR_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d;
    logic [1:0]              vld_q, vld_d;
    logic [ADDR_W-1:0]       addr0_q, addr0_d;
    logic [ADDR_W-1:0]       addr1_q, addr1_d;
    logic                    ptr_q, ptr_d;
    logic                    done_q, done_d;
    logic [15:0]             issued_q, issued_d;

    logic              xfer0, xfer1, free0, free1;
    logic              load, sel;
    logic [ADDR_W-1:0] load_addr;

    // Next line address: stride is in 64B lines, wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] base,
                                                    input logic signed [STR_W-1:0] s);
        logic [ADDR_W-1:0] ofs;
        ofs = ADDR_W'(s);
        return base + (ofs << 6);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
        logic [16:0] sum;
        sum = {1'b0, c} + 17'(n);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_comb begin
        xfer0 = vld_q[0] & ~req0_retry;
        xfer1 = vld_q[1] & ~req1_retry;
        free0 = ~vld_q[0] | xfer0;
        free1 = ~vld_q[1] | xfer1;

        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        stride_d    = stride_q;
        remaining_d = remaining_q;
        vld_d       = {vld_q[1] & ~xfer1, vld_q[0] & ~xfer0};
        addr0_d     = addr0_q;
        addr1_d     = addr1_q;
        ptr_d       = ptr_q;
        done_d      = 1'b0;
        issued_d    = sat_add(issued_q, {1'b0, xfer0} + {1'b0, xfer1});
        load        = 1'b0;
        load_addr   = '0;
        sel         = 1'b0;

        case (state_q)
            IDLE: begin
                // The first line goes straight into a port so it is valid next cycle.
                if (op_valid && op_count != '0) begin
                    load        = 1'b1;
                    load_addr   = op_addr & ~ADDR_W'(63);
                    cur_addr_d  = step_addr(load_addr, op_stride);
                    stride_d    = op_stride;
                    remaining_d = op_count - CNT_W'(1);
                    state_d     = (op_count == CNT_W'(1)) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (free0 | free1) begin
                    load        = 1'b1;
                    load_addr   = cur_addr_q;
                    cur_addr_d  = step_addr(cur_addr_q, stride_q);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!vld_d[0] && !vld_d[1]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sel        = (free0 && free1) ? ptr_q : free1;
            vld_d[sel] = 1'b1;
            if (sel) addr1_d = load_addr;
            else     addr0_d = load_addr;
            ptr_d      = ~sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            vld_q       <= '0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            ptr_q       <= 1'b0;
            done_q      <= 1'b0;
            issued_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
            vld_q       <= vld_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            issued_q    <= issued_d;
        end
    end

    assign op_retry   = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign req0_valid = vld_q[0];
    assign req1_valid = vld_q[1];
    assign req0_addr  = addr0_q;
    assign req1_addr  = addr1_q;
    assign done       = done_q;
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_pfe_req_sched.sv
// Bench for pfe_req_sched: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed transfer logs.
module tb_pfe_req_sched;
    localparam int AW = 50;
    typedef logic [AW-1:0] addr_t;
    localparam longint MASK = (64'sd1 <<< AW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        opv = 1'b0;
    logic        op_retry;
    addr_t       op_addr = '0;
    logic [7:0]  op_stride = '0;
    logic [3:0]  op_count = '0;
    logic        v0, v1, r0 = 1'b0, r1 = 1'b0;
    addr_t       a0, a1;
    logic        busy, done;
    logic [15:0] issued;

    pfe_req_sched dut (
        .clk(clk), .reset(rst), .op_valid(opv), .op_retry(op_retry),
        .op_addr(op_addr), .op_stride(op_stride), .op_count(op_count),
        .req0_valid(v0), .req0_retry(r0), .req0_addr(a0),
        .req1_valid(v1), .req1_retry(r1), .req1_addr(a1),
        .busy(busy), .done(done), .issued_cnt(issued)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit started = 1'b0;

    // Reference model: pending line addresses live in a queue, ports are two slots.
    addr_t m_q[$];
    bit [1:0] m_v = '0;
    addr_t m_a[2] = '{default: '0};
    bit m_ptr = 1'b0;
    bit m_done = 1'b0;
    int m_cnt = 0;

    // Observed transfer log and pulse counters.
    int    log_port[$];
    addr_t log_addr[$];
    int    log_cyc[$];
    int    n_done = 0;
    int    n_busy = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit x0, x1, f0, f1, bsy, p;
        longint base, st;
        if (rst) begin
            m_q.delete();
            m_v = '0; m_a[0] = '0; m_a[1] = '0;
            m_ptr = 1'b0; m_done = 1'b0; m_cnt = 0;
            return;
        end
        x0 = m_v[0] && !r0;
        x1 = m_v[1] && !r1;
        bsy = (m_q.size() > 0) || (m_v != 0);
        m_done = bsy && m_q.size() == 0 && (x0 || x1) && (!m_v[0] || x0) && (!m_v[1] || x1);
        m_cnt = m_cnt + int'(x0) + int'(x1);
        if (m_cnt > 65535) m_cnt = 65535;
        f0 = !m_v[0] || x0;
        f1 = !m_v[1] || x1;
        m_v[0] = m_v[0] && !x0;
        m_v[1] = m_v[1] && !x1;
        if (!bsy && opv && op_count != 0) begin
            base = longint'(op_addr) & ~longint'(63);
            st = longint'($signed(op_stride));
            for (int i = 0; i < int'(op_count); i++)
                m_q.push_back(addr_t'((base + longint'(i) * st * 64) & MASK));
        end
        if (m_q.size() > 0 && (f0 || f1)) begin
            p = (f0 && f1) ? m_ptr : f1;
            m_v[p] = 1'b1;
            m_a[p] = m_q.pop_front();
            m_ptr = !p;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("req0_valid", 64'(v0), 64'(m_v[0]));
            check("req1_valid", 64'(v1), 64'(m_v[1]));
            check("req0_addr", 64'(a0), 64'(m_a[0]));
            check("req1_addr", 64'(a1), 64'(m_a[1]));
            check("busy", 64'(busy), 64'((m_q.size() > 0) || (m_v != 0)));
            check("op_retry", 64'(op_retry), 64'((m_q.size() > 0) || (m_v != 0)));
            check("done", 64'(done), 64'(m_done));
            check("issued_cnt", 64'(issued), 64'(m_cnt));
            if (!rst && v0 === 1'b1 && !r0) begin
                log_port.push_back(0); log_addr.push_back(a0); log_cyc.push_back(cyc);
            end
            if (!rst && v1 === 1'b1 && !r1) begin
                log_port.push_back(1); log_addr.push_back(a1); log_cyc.push_back(cyc);
            end
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
    end

    task automatic clear_logs();
        log_port.delete(); log_addr.delete(); log_cyc.delete();
        n_done = 0; n_busy = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; opv = 1'b0; r0 = 1'b0; r1 = 1'b0;
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_v0", 64'(v0), 64'd0);
        check("rst_v1", 64'(v1), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_retry", 64'(op_retry), 64'd0);
        check("rst_issued", 64'(issued), 64'd0);
        clear_logs();
    endtask

    task automatic offer(input addr_t ad, input logic [7:0] st, input logic [3:0] cn);
        opv = 1'b1; op_addr = ad; op_stride = st; op_count = cn;
    endtask

    task automatic check_log(input string nm, input int idx, input int port, input addr_t ad);
        if (idx < log_port.size()) begin
            check({nm, "_port"}, 64'(log_port[idx]), 64'(port));
            check({nm, "_addr"}, 64'(log_addr[idx]), 64'(ad));
        end else begin
            check({nm, "_missing"}, 64'(log_port.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        // Four-line op, no retries: alternating ports on consecutive cycles.
        do_reset();
        offer(50'h1000, 8'd1, 4'd4);
        tick(); opv = 1'b0;
        repeat (8) tick();
        check("t1_n", 64'(log_port.size()), 64'd4);
        check_log("t1_0", 0, 0, 50'h1000);
        check_log("t1_1", 1, 1, 50'h1040);
        check_log("t1_2", 2, 0, 50'h1080);
        check_log("t1_3", 3, 1, 50'h10C0);
        if (log_cyc.size() == 4) check("t1_consec", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
        check("t1_done", 64'(n_done), 64'd1);
        check("t1_issued", 64'(issued), 64'd4);

        // Negative stride with port 0 stalled for five cycles.
        do_reset();
        offer(50'h2000, 8'hFE, 4'd3);
        tick(); opv = 1'b0; r0 = 1'b1;
        repeat (5) tick();
        r0 = 1'b0;
        repeat (6) tick();
        check("t2_n", 64'(log_port.size()), 64'd3);
        check_log("t2_0", 0, 1, 50'h1F80);
        check_log("t2_1", 1, 1, 50'h1F00);
        check_log("t2_2", 2, 0, 50'h2000);
        check("t2_done", 64'(n_done), 64'd1);

        // Zero-count op is dropped.
        do_reset();
        offer(50'h3000, 8'd1, 4'd0);
        tick(); opv = 1'b0;
        repeat (4) tick();
        check("t3_n", 64'(log_port.size()), 64'd0);
        check("t3_done", 64'(n_done), 64'd0);
        check("t3_busy", 64'(n_busy), 64'd0);

        // op_valid held: second op accepted on the first IDLE cycle.
        do_reset();
        offer(50'h4000, 8'd1, 4'd2);
        repeat (4) tick();
        opv = 1'b0;
        repeat (6) tick();
        check("t4_n", 64'(log_port.size()), 64'd4);
        check_log("t4_0", 0, 0, 50'h4000);
        check_log("t4_1", 1, 1, 50'h4040);
        check_log("t4_2", 2, 0, 50'h4000);
        check_log("t4_3", 3, 1, 50'h4040);
        if (log_cyc.size() == 4) check("t4_gap", 64'(log_cyc[2] - log_cyc[0]), 64'd3);
        check("t4_done", 64'(n_done), 64'd2);

        // Address wrap-around at the top of the address space.
        do_reset();
        offer(addr_t'(MASK - 63), 8'd1, 4'd2);
        tick(); opv = 1'b0;
        repeat (5) tick();
        check_log("t5_0", 0, 0, addr_t'(MASK - 63));
        check_log("t5_1", 1, 1, 50'h0);

        // Reset mid-op with both ports holding requests.
        do_reset();
        r0 = 1'b1; r1 = 1'b1;
        offer(50'h5000, 8'd3, 4'd4);
        tick(); opv = 1'b0;
        repeat (2) tick();
        check("t6_both_v0", 64'(v0), 64'd1);
        check("t6_both_v1", 64'(v1), 64'd1);
        rst = 1'b1;
        tick();
        check("t6_v0", 64'(v0), 64'd0);
        check("t6_v1", 64'(v1), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_issued", 64'(issued), 64'd0);
        rst = 1'b0; r0 = 1'b0; r1 = 1'b0;
        repeat (3) tick();
        check("t6_done", 64'(n_done), 64'd0);
        check("t6_n", 64'(log_port.size()), 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            opv = ($urandom_range(0, 3) != 0);
            op_addr = ($urandom_range(0, 7) == 0) ? addr_t'(MASK - 64 * $urandom_range(0, 3))
                                                  : addr_t'({$urandom(), $urandom()});
            op_stride = 8'($urandom());
            op_count = 4'($urandom());
            r0 = ($urandom_range(0, 3) == 0);
            r1 = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0; opv = 1'b0; r0 = 1'b0; r1 = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
